// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// Covers opcodes/functs, ALU ops, datapath mux selects, FSM states and the DECODE dispatch.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] ALU_ADDU = 2'b00;
  localparam logic [1:0] ALU_SUBU = 2'b01;
  localparam logic [1:0] ALU_ORI  = 2'b10;
  localparam logic [1:0] ALU_LUI  = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  // Successor of DECODE; S_FETCH means the op/funct pair is unsupported.
  function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] funct);
    state_t t;
    t = S_FETCH;
    case (op)
      OP_RTYPE:      if (funct == FN_ADDU || funct == FN_SUBU) t = S_REXEC;
      OP_ORI, OP_LUI: t = S_IEXEC;
      OP_LW, OP_SW:  t = S_MEMADR;
      OP_BEQ:        t = S_BRANCH;
      OP_J:          t = S_JUMP;
      default:       t = S_FETCH;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: state register is the only storage, all outputs combinational.
// CPI 3..5 with ready memory; FETCH/MEMRD/MEMWR hold indefinitely while mem_ready is low.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int FN_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic [FN_W-1:0] funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            iord,
  output logic            mem_req,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            ext_op,
  output logic [1:0]      alu_ctl,
  output logic [1:0]      pc_source,
  output logic            illegal,
  output logic            instr_done,
  output logic [3:0]      state
);

  state_t state_q;
  state_t state_n;
  state_t dec_tgt;

  assign dec_tgt = decode_target(op, funct);
  assign state   = state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = S_FETCH;
    case (state_q)
      S_FETCH:  state_n = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_n = dec_tgt;
      S_MEMADR: state_n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_n = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_n = mem_ready ? S_FETCH : S_MEMWR;
      S_REXEC:  state_n = S_RWB;
      S_IEXEC:  state_n = S_IWB;
      default:  state_n = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    ext_op     = 1'b0;
    alu_ctl    = ALU_ADDU;
    pc_source  = PCSRC_ALU;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        ext_op    = 1'b1;
        illegal   = (dec_tgt == S_FETCH);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_op    = 1'b1;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_ctl   = (funct == FN_SUBU) ? ALU_SUBU : ALU_ADDU;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctl   = (op == OP_LUI) ? ALU_LUI : ALU_ORI;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctl    = ALU_SUBU;
        pc_source  = PCSRC_ALUOUT;
        pc_write   = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Reset squashes every side effect regardless of where the FSM was.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
